// File: rtl/quat_rot_mat_pipe_if.sv
// Handshake bundle for quat_rot_mat_pipe.
//   master : producer/consumer side; drives quaternion, transpose and out_ready.
//   slave  : converter side; drives in_ready, out_valid, matrix_out, out_ovf.
// Signals:
//   in_valid/in_ready   input handshake; w, x, y, z and in_transpose qualify in_valid
//   out_valid/out_ready output handshake; matrix_out[row][col] and out_ovf qualify out_valid
interface quat_rot_mat_pipe_if #(
  parameter int DATA_WIDTH = 32
);
  logic                             in_valid;
  logic                             in_ready;
  logic                             in_transpose;
  logic [DATA_WIDTH-1:0]            w;
  logic [DATA_WIDTH-1:0]            x;
  logic [DATA_WIDTH-1:0]            y;
  logic [DATA_WIDTH-1:0]            z;
  logic                             out_valid;
  logic                             out_ready;
  logic [2:0][2:0][DATA_WIDTH-1:0]  matrix_out;
  logic                             out_ovf;

  modport master (
    output in_valid, in_transpose, w, x, y, z, out_ready,
    input  in_ready, out_valid, matrix_out, out_ovf
  );

  modport slave (
    input  in_valid, in_transpose, w, x, y, z, out_ready,
    output in_ready, out_valid, matrix_out, out_ovf
  );
endinterface

// File: rtl/quat_rot_mat_pipe.sv
// Unit quaternion (w, x, y, z) to 3x3 rotation matrix, three register stages.
//   S1: nine two-term dot products (exact products, single RNE rounding)
//   S2: doubling by exponent increment, minus 1.0 on the diagonal, overflow OR
//   S3: optional transpose into the output register
// Ports:
//   clk  clock
//   rst  synchronous active-high reset; drops everything in flight
//   bus  slave side of quat_rot_mat_pipe_if (valid/ready in, valid/ready out)
// All stages advance together when the output is empty or being taken, so a
// pop and an accept can share a cycle and throughput is one matrix per clock.
// Denormal operands and results are flushed to signed zero.
module quat_rot_mat_pipe #(
  parameter int SIG_WIDTH       = 23,
  parameter int EXP_WIDTH       = 8,
  parameter int IEEE_COMPLIANCE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  quat_rot_mat_pipe_if.slave   bus
);

  localparam int DATA_WIDTH = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int SW   = SIG_WIDTH;
  localparam int EW   = EXP_WIDTH;
  localparam int EH   = DATA_WIDTH - 2;        // top bit of the exponent field
  localparam int MW   = SW + 1;                // significand with hidden one
  localparam int PW   = 2 * MW;                // exact product width
  localparam int XW   = PW + 3;                // product plus guard/round/sticky
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int EMAX = (1 << EW) - 1;

  localparam logic [DATA_WIDTH-1:0] ONE     = {2'b00, {(EW-1){1'b1}}, {SW{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] NEG_ONE = {2'b10, {(EW-1){1'b1}}, {SW{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] QNAN    = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] INF_POS = {1'b0, {EW{1'b1}}, {SW{1'b0}}};

  // a*b + c*d with both products kept exact and one final round-to-nearest-even.
  function automatic logic [DATA_WIDTH-1:0] fp_dp2(
    input logic [DATA_WIDTH-1:0] a, b, c, d
  );
    logic                 s1, s2, sl, ss, z1, z2, inf1, inf2, st, g, up;
    logic [PW-1:0]        p1, p2, pl, ps;
    logic [XW-1:0]        xs, sh, mask, nrm;
    logic [XW:0]          sum;
    logic [SW-1:0]        man;
    logic [SW:0]          rnd;
    int                   ep1, ep2, epl, diff, k, er;

    s1   = a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
    s2   = c[DATA_WIDTH-1] ^ d[DATA_WIDTH-1];
    z1   = (a[EH:SW] == '0) | (b[EH:SW] == '0);
    z2   = (c[EH:SW] == '0) | (d[EH:SW] == '0);
    inf1 = (a[EH:SW] == '1) | (b[EH:SW] == '1);
    inf2 = (c[EH:SW] == '1) | (d[EH:SW] == '1);

    if (inf1 | inf2) begin
      if (inf1 & inf2 & (s1 != s2))
        return (IEEE_COMPLIANCE != 0) ? QNAN : INF_POS;
      return {(inf1 ? s1 : s2), {EW{1'b1}}, {SW{1'b0}}};
    end

    p1  = z1 ? '0 : ({{MW{1'b0}}, 1'b1, a[SW-1:0]} * {{MW{1'b0}}, 1'b1, b[SW-1:0]});
    p2  = z2 ? '0 : ({{MW{1'b0}}, 1'b1, c[SW-1:0]} * {{MW{1'b0}}, 1'b1, d[SW-1:0]});
    ep1 = z1 ? 0 : int'(a[EH:SW]) + int'(b[EH:SW]);
    ep2 = z2 ? 0 : int'(c[EH:SW]) + int'(d[EH:SW]);

    // Order by magnitude so subtraction never goes negative.
    if ((ep1 > ep2) || ((ep1 == ep2) && (p1 >= p2))) begin
      pl = p1; ps = p2; sl = s1; ss = s2; epl = ep1; diff = ep1 - ep2;
    end else begin
      pl = p2; ps = p1; sl = s2; ss = s1; epl = ep2; diff = ep2 - ep1;
    end

    xs = {ps, 3'b000};
    if (diff >= XW) begin
      sh = '0;
      st = |xs;
    end else begin
      mask = ~({XW{1'b1}} << diff);
      sh   = xs >> diff;
      st   = |(xs & mask);
    end
    sh[0] = sh[0] | st;

    sum = (sl == ss) ? ({1'b0, pl, 3'b000} + {1'b0, sh})
                     : ({1'b0, pl, 3'b000} - {1'b0, sh});

    // Exact cancellation gives +0; two zero products keep a common sign.
    if (sum == '0)
      return {s1 & s2, {(DATA_WIDTH-1){1'b0}}};

    k = 0;
    for (int i = 0; i <= XW; i++)
      if (sum[i]) k = i;

    // Leading one is shifted out of the top; what remains is the fraction.
    nrm = sum[XW-1:0] << (XW - k);
    man = nrm[XW-1 -: SW];
    g   = nrm[XW-1-SW];
    st  = |nrm[XW-2-SW:0];
    up  = g & (st | man[0]);
    rnd = {1'b0, man} + {{SW{1'b0}}, up};

    er = k + epl - BIAS - 2 * SW - 3;
    if (rnd[SW]) er = er + 1;

    if (er <= 0)
      return {sl, {(DATA_WIDTH-1){1'b0}}};
    if (er >= EMAX)
      return {sl, {EW{1'b1}}, {SW{1'b0}}};
    return {sl, er[EW-1:0], rnd[SW-1:0]};
  endfunction

  // Times two by exponent increment; MSB of the result is the saturation flag.
  function automatic logic [DATA_WIDTH:0] fp_dbl(input logic [DATA_WIDTH-1:0] v);
    logic [EW-1:0] e;
    e = v[EH:SW];
    if ((e == '0) || (e == '1))
      return {1'b0, v};
    if (e == {{(EW-1){1'b1}}, 1'b0})
      return {1'b1, v[DATA_WIDTH-1], {EW{1'b1}}, {SW{1'b0}}};
    return {1'b0, v[DATA_WIDTH-1], e + 1'b1, v[SW-1:0]};
  endfunction

  logic                              advance;
  logic                              v1_q, v2_q, v3_q;
  logic                              tr1_q, tr2_q;
  logic                              ovf2_q, ovf3_q, ovf_d;
  logic [DATA_WIDTH-1:0]             wn;
  logic [DATA_WIDTH:0]               dbl;
  logic [8:0][DATA_WIDTH-1:0]        dp_d, dp_q;
  logic [8:0][DATA_WIDTH-1:0]        el_d, el_q;
  logic [2:0][2:0][DATA_WIDTH-1:0]   mat_d, mat_q;

  assign advance        = !v3_q | bus.out_ready;
  assign bus.in_ready   = advance;
  assign bus.out_valid  = v3_q;
  assign bus.out_ovf    = ovf3_q;
  assign bus.matrix_out = mat_q;

  // Row-major r[i][j] at index 3*i+j; negated terms use w with its sign flipped.
  assign wn = {~bus.w[DATA_WIDTH-1], bus.w[DATA_WIDTH-2:0]};

  always_comb begin
    dp_d    = '0;
    dp_d[0] = fp_dp2(bus.w, bus.w, bus.x, bus.x);
    dp_d[1] = fp_dp2(bus.x, bus.y, wn,    bus.z);
    dp_d[2] = fp_dp2(bus.x, bus.z, bus.w, bus.y);
    dp_d[3] = fp_dp2(bus.x, bus.y, bus.w, bus.z);
    dp_d[4] = fp_dp2(bus.w, bus.w, bus.y, bus.y);
    dp_d[5] = fp_dp2(bus.y, bus.z, wn,    bus.x);
    dp_d[6] = fp_dp2(bus.x, bus.z, wn,    bus.y);
    dp_d[7] = fp_dp2(bus.y, bus.z, bus.w, bus.x);
    dp_d[8] = fp_dp2(bus.w, bus.w, bus.z, bus.z);
  end

  // Diagonal: 2s - 1 computed as 2s*1 + (-1)*1 through the same dot product.
  always_comb begin
    el_d  = '0;
    ovf_d = 1'b0;
    dbl   = '0;
    for (int i = 0; i < 9; i++) begin
      dbl   = fp_dbl(dp_q[i]);
      ovf_d = ovf_d | dbl[DATA_WIDTH];
      if ((i % 4) == 0)
        el_d[i] = fp_dp2(dbl[DATA_WIDTH-1:0], ONE, NEG_ONE, ONE);
      else
        el_d[i] = dbl[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    mat_d = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        mat_d[r][c] = tr2_q ? el_q[c*3 + r] : el_q[r*3 + c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      tr1_q  <= 1'b0;
      tr2_q  <= 1'b0;
      ovf2_q <= 1'b0;
      ovf3_q <= 1'b0;
      dp_q   <= '0;
      el_q   <= '0;
      mat_q  <= '0;
    end else if (advance) begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (bus.in_valid) begin
        dp_q  <= dp_d;
        tr1_q <= bus.in_transpose;
      end
      if (v1_q) begin
        el_q   <= el_d;
        ovf2_q <= ovf_d;
        tr2_q  <= tr1_q;
      end
      if (v2_q) begin
        mat_q  <= mat_d;
        ovf3_q <= ovf2_q;
      end
    end
  end

endmodule

// File: tb/tb_quat_rot_mat_pipe.sv
module tb_quat_rot_mat_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quat_rot_mat_pipe_if #(.DATA_WIDTH(32)) bus32 ();
  quat_rot_mat_pipe_if #(.DATA_WIDTH(16)) bus16 ();

  quat_rot_mat_pipe u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  quat_rot_mat_pipe #(.SIG_WIDTH(10), .EXP_WIDTH(5)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  localparam logic [31:0] F_ONE  = 32'h3F80_0000;
  localparam logic [31:0] F_HALF = 32'h3F00_0000;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  // kind 0 = identity, kind 1 = cyclic rotation (all components 0.5)
  function automatic bit is_one(input int kind, input bit tr, input int r, input int c);
    if (kind == 0) return (r == c);
    if (tr)        return (c == (r + 1) % 3);
    return (c == (r + 2) % 3);
  endfunction

  task automatic check_rot(input string tag, input int kind, input bit tr);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (is_one(kind, tr, r, c))
          check($sformatf("%s[%0d][%0d]", tag, r, c), bus32.matrix_out[r][c], F_ONE);
        else
          check($sformatf("%s[%0d][%0d]", tag, r, c),
                bus32.matrix_out[r][c] & 32'h7FFF_FFFF, 32'h0);
  endtask

  task automatic drive32(input logic [31:0] qw, qx, qy, qz, input bit tr);
    bus32.w            = qw;
    bus32.x            = qx;
    bus32.y            = qy;
    bus32.z            = qz;
    bus32.in_transpose = tr;
    bus32.in_valid     = 1'b1;
  endtask

  task automatic drive_kind(input int kind, input bit tr);
    if (kind == 0) drive32(F_ONE, 32'h0, 32'h0, 32'h0, tr);
    else           drive32(F_HALF, F_HALF, F_HALF, F_HALF, tr);
  endtask

  // Presents one quaternion, returns edges until out_valid (20 = timed out).
  task automatic run_one(input logic [31:0] qw, qx, qy, qz, input bit tr, output int lat);
    @(negedge clk);
    drive32(qw, qx, qy, qz, tr);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    lat = 1;
    while (!bus32.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, sent, rcvd, cyc, bubbles, extra;
    logic [2:0][2:0][31:0] snap;

    rst                = 1'b1;
    bus32.in_valid     = 1'b0;
    bus32.in_transpose = 1'b0;
    bus32.w            = '0;
    bus32.x            = '0;
    bus32.y            = '0;
    bus32.z            = '0;
    bus32.out_ready    = 1'b1;
    bus16.in_valid     = 1'b0;
    bus16.in_transpose = 1'b0;
    bus16.w            = '0;
    bus16.x            = '0;
    bus16.y            = '0;
    bus16.z            = '0;
    bus16.out_ready    = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus32.out_valid, 0);
    check("rst_out_ovf", bus32.out_ovf, 0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("rst_mat[%0d][%0d]", r, c), bus32.matrix_out[r][c], 32'h0);
    rst = 1'b0;
    check("post_rst_in_ready", bus32.in_ready, 1);

    // Identity
    run_one(F_ONE, 32'h0, 32'h0, 32'h0, 1'b0, lat);
    check("ident_latency", lat, 3);
    check_rot("ident", 0, 1'b0);
    check("ident_ovf", bus32.out_ovf, 0);

    // Cyclic rotation, both orientations
    run_one(F_HALF, F_HALF, F_HALF, F_HALF, 1'b0, lat);
    check("cyc_latency", lat, 3);
    check_rot("cyc", 1, 1'b0);
    run_one(F_HALF, F_HALF, F_HALF, F_HALF, 1'b1, lat);
    check("cyc_t_latency", lat, 3);
    check_rot("cyc_t", 1, 1'b1);

    // Doubling saturation: w = x = 2^63 gives w^2+x^2 = 2^127, doubled -> inf
    run_one(32'h5F00_0000, 32'h5F00_0000, 32'h0, 32'h0, 1'b0, lat);
    check("ovf_latency", lat, 3);
    check("ovf_r00", bus32.matrix_out[0][0], 32'h7F80_0000);
    check("ovf_r11", bus32.matrix_out[1][1], 32'h7F00_0000);
    check("ovf_r12", bus32.matrix_out[1][2], 32'hFF00_0000);
    check("ovf_r21", bus32.matrix_out[2][1], 32'h7F00_0000);
    check("ovf_flag", bus32.out_ovf, 1);
    run_one(F_ONE, 32'h0, 32'h0, 32'h0, 1'b0, lat);
    check("ovf_next_flag", bus32.out_ovf, 0);
    check("ovf_next_r00", bus32.matrix_out[0][0], F_ONE);

    // w = x = 2^127: the dot product itself already saturates to inf
    run_one(32'h7F00_0000, 32'h7F00_0000, 32'h0, 32'h0, 1'b0, lat);
    check("big_r00", bus32.matrix_out[0][0], 32'h7F80_0000);

    // Streaming with a 5-cycle output stall
    sent = 0; rcvd = 0; cyc = 0; bubbles = 0; snap = '0;
    while (rcvd < 8 && cyc < 100) begin
      @(negedge clk);
      bus32.out_ready = !(cyc >= 6 && cyc <= 10);
      if (sent < 8) drive_kind(sent % 2, 1'((sent >> 1) & 1));
      else          bus32.in_valid = 1'b0;
      #1;
      if (!bus32.out_ready) begin
        check($sformatf("stall_in_ready_c%0d", cyc), bus32.in_ready, 0);
        if (cyc == 6) snap = bus32.matrix_out;
        else check($sformatf("stall_hold_c%0d", cyc), {31'b0, bus32.matrix_out == snap}, 1);
      end
      if (bus32.out_valid && bus32.out_ready) begin
        check_rot($sformatf("stream%0d", rcvd), rcvd % 2, 1'((rcvd >> 1) & 1));
        rcvd++;
      end else if (bus32.out_ready && rcvd > 0) begin
        bubbles++;
      end
      if (bus32.in_valid && bus32.in_ready) sent++;
      cyc++;
    end
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus32.out_valid) extra++;
    end
    check("stream_rcvd", rcvd, 8);
    check("stream_cycles", cyc, 16);
    check("stream_bubbles", bubbles, 0);
    check("stream_extra", extra, 0);

    // Reset while two quaternions are in flight
    @(negedge clk);
    drive_kind(0, 1'b0);
    @(negedge clk);
    drive_kind(1, 1'b0);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", bus32.out_valid, 0);
    check("midrst_in_ready", bus32.in_ready, 1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus32.out_valid) extra++;
    end
    check("midrst_stale", extra, 0);
    run_one(F_ONE, 32'h0, 32'h0, 32'h0, 1'b0, lat);
    check("midrst_latency", lat, 3);
    check_rot("midrst_ident", 0, 1'b0);

    // Half-precision build, cyclic rotation
    @(negedge clk);
    bus16.w            = 16'h3800;
    bus16.x            = 16'h3800;
    bus16.y            = 16'h3800;
    bus16.z            = 16'h3800;
    bus16.in_transpose = 1'b0;
    bus16.in_valid     = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("half_latency", lat, 3);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (is_one(1, 1'b0, r, c))
          check($sformatf("half[%0d][%0d]", r, c), {16'h0, bus16.matrix_out[r][c]}, 32'h3C00);
        else
          check($sformatf("half[%0d][%0d]", r, c),
                {16'h0, bus16.matrix_out[r][c] & 16'h7FFF}, 32'h0);
    check("half_ovf", bus16.out_ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
